// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits, odd parity,
// stop, then sample the device ACK. Drives open-collector pads through *_oe.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_US     = 100,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);
  localparam int INHIBIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE} state_t;

  logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic          data_meta_q, data_meta_d, data_sync_q, data_sync_d;
  logic          filt_q, filt_d, fall_q, fall_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  state_t        state_q, state_d;
  logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic          tx_ready_q, tx_ready_d, busy_q, busy_d;
  logic          done_q, done_d, err_q, err_d;
  logic          ack_ok_q, ack_ok_d, ack_smp_q, ack_smp_d;
  logic [8:0]    frame_q, frame_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Input conditioning: the filtered clock only flips after FILTER_LEN agreeing samples.
  always_comb begin
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;
    filt_d      = filt_q;
    fcnt_d      = '0;
    if (clk_sync_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;
  end

  always_comb begin
    state_d   = state_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = '0;
    ack_smp_d = ack_smp_q;
    ack_ok_d  = ack_ok_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready_q) begin
          frame_d   = {~^tx_data, tx_data};
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // Start bit goes low one cycle before the clock is released.
        if (inh_cnt_q == IW'(INHIBIT_CYCLES - 2)) data_oe_d = 1'b1;
        if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = RTS;
        end
      end
      RTS: begin
        if (fall_q) begin
          data_oe_d = ~frame_q[0];
          bit_cnt_d = 4'd1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (fall_q) begin
          if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~frame_q[bit_cnt_q];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ACK: begin
        if (fall_q) begin
          ack_smp_d = ~data_sync_q;
          state_d   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (filt_q && data_sync_q) begin
          done_d   = 1'b1;
          ack_ok_d = ack_smp_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Device-clock watchdog; a falling edge in the same cycle restarts it instead.
    if (state_q inside {RTS, DATA, ACK, WAIT_IDLE} && !fall_q) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        to_cnt_d  = '0;
        err_d     = 1'b1;
        done_d    = 1'b0;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    end

    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      fall_q      <= 1'b0;
      state_q     <= IDLE;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      tx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ack_ok_q    <= 1'b0;
      ack_smp_q   <= 1'b0;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ack_ok_q    <= ack_ok_d;
      ack_smp_q   <= ack_smp_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ack_ok      = ack_ok_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames at 12.5 kHz; expected
// responses and frame bits are queued at stimulus time and checked by monitors.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int CLK_HZ = 4_000_000;
  localparam int INH_US = 100;
  localparam int TO     = 2000;
  localparam int FL     = 4;
  localparam int INH    = CLK_HZ / 1_000_000 * INH_US;  // 400 cycles
  localparam int HALF   = 160;                          // 12.5 kHz half period
  localparam int QTR    = 40;

  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic busy, done, ack_ok, err;
  logic dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk & ~glitch;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.CLK_FREQ_HZ(CLK_HZ), .INHIBIT_US(INH_US), .TIMEOUT_CYCLES(TO),
                .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .ack_ok(ack_ok), .err(err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic is_err; logic ack; } resp_t;
  resp_t       resp_q[$];
  logic [10:0] frame_q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expired(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Response monitor: inhibit timing, RTS overlap, and done/err against the queue.
  initial begin
    int inh_run, ovl, rts_cyc;
    logic prev_oe;
    resp_t r;
    inh_run = 0; ovl = 0; rts_cyc = 0; prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (ps2_clk_oe) begin
          inh_run++;
          if (ps2_data_oe) ovl++;
        end else if (prev_oe) begin
          chk("inhibit_len", inh_run, INH);
          chk("start_overlap", 32'(ovl >= 1), 1);
          chk("rts_data_low", ps2_data_oe, 1);
          rts_cyc = cyc;
          inh_run = 0;
          ovl = 0;
        end
        prev_oe = ps2_clk_oe;
        if (done || err) begin
          if (resp_q.size() == 0) chk("unexpected_resp", {done, err}, 0);
          else begin
            r = resp_q.pop_front();
            chk("resp_err", err, r.is_err);
            chk("resp_done", done, !r.is_err);
            if (!r.is_err) chk("ack_ok", ack_ok, r.ack);
            else begin
              chk("timeout_cycles", cyc - rts_cyc, TO);
              chk("err_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
            end
            chk("ready_on_finish", {tx_ready, busy}, 2'b10);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (!tx_ready && t < 10000) begin @(negedge clk); t++; end
    if (t >= 10000) expired("send_ready");
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_finish(input int lim);
    int t;
    t = 0;
    while (!(done || err) && t < lim) begin @(negedge clk); t++; end
    if (t >= lim) expired("wait_finish");
  endtask

  // Device model: samples start before the first fall, then on rises 1..10; clock 11 is ACK.
  task automatic device_frame(input bit do_ack, input int glitch_at, input int stop_after);
    logic [10:0] smp, exp;
    int t;
    smp = '0;
    t = 0;
    while (!(busy && !ps2_clk_oe && ps2_data_oe) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) begin expired("rts_wait"); return; end
    repeat (50) @(negedge clk);
    smp[0] = ps2_data_in;
    for (int i = 1; i <= 11; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) smp[i] = ps2_data_in;
      if (i == stop_after) return;
      if (i == 11) begin
        dev_data = 1'b1;
        break;
      end
      repeat (QTR) @(negedge clk);
      if (i == glitch_at) begin
        glitch = 1'b1;
        repeat (2) @(negedge clk);
        glitch = 1'b0;
      end
      if (i == 10 && do_ack) dev_data = 1'b0;
      repeat (HALF - QTR) @(negedge clk);
    end
    if (frame_q.size() == 0) expired("frame_queue_empty");
    else begin
      exp = frame_q.pop_front();
      chk("frame_bits", smp, exp);
    end
  endtask

  initial begin
    int bcnt;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ack_ok", ack_ok, 0);
    rst = 1'b1;
    @(negedge clk);

    // Reset mid-frame during DATA
    send(8'hF4);
    device_frame(1'b1, 0, 3);
    chk("busy_in_data", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("midrst_ready_busy", {tx_ready, busy}, 2'b10);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // 0xF4 after reset, ACKed
    resp_q.push_back(resp_t'{1'b0, 1'b1}); frame_q.push_back(11'h5E8);
    send(8'hF4); device_frame(1'b1, 0, 0); wait_finish(500);
    @(negedge clk);

    // 0xED: bits 0,1,0,1,1,0,1,1,1,1,1
    resp_q.push_back(resp_t'{1'b0, 1'b1}); frame_q.push_back(11'h7DA);
    send(8'hED); device_frame(1'b1, 0, 0); wait_finish(500);
    @(negedge clk);

    // 0x01, parity 0, device does not ACK
    resp_q.push_back(resp_t'{1'b0, 1'b0}); frame_q.push_back(11'h402);
    send(8'h01); device_frame(1'b0, 0, 0); wait_finish(500);
    @(negedge clk);

    // Silent device -> timeout
    resp_q.push_back(resp_t'{1'b1, 1'b0});
    send(8'h55); wait_finish(INH + TO + 200);
    @(negedge clk);

    // Glitch on clock during DATA, plus a request while busy
    resp_q.push_back(resp_t'{1'b0, 1'b1}); frame_q.push_back(11'h74A);
    send(8'hA5);
    repeat (5) @(negedge clk);
    tx_data = 8'h3C; tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
    device_frame(1'b1, 5, 0); wait_finish(500);
    bcnt = 0;
    repeat (INH + TO + 200) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("no_extra_frame", bcnt, 0);

    // Back-to-back 0xFF then 0xF4 with tx_valid held
    resp_q.push_back(resp_t'{1'b0, 1'b1}); frame_q.push_back(11'h7FE);
    resp_q.push_back(resp_t'{1'b0, 1'b1}); frame_q.push_back(11'h5E8);
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hF4;
    device_frame(1'b1, 0, 0); wait_finish(500);
    @(negedge clk);
    chk("b2b_accept_next_cycle", {ps2_clk_oe, busy}, 2'b11);
    tx_valid = 1'b0;
    device_frame(1'b1, 0, 0); wait_finish(500);

    repeat (20) @(negedge clk);
    chk("resp_queue_drained", resp_q.size(), 0);
    chk("frame_queue_drained", frame_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
